tdoa_xcorr: RTL

Time-difference-of-arrival estimator for the microphone array. Sits directly downstream of the per-mic I2S receivers, running in parallel with the anti-alias filter, and consumes two raw 16-bit mic streams with their valid strobes. On request it captures a fixed window from each mic, then serially cross-correlates the two windows over a bounded lag range. It reports the lag of the correlation peak, in samples, for source localisation and distance logic.

---
 rtl/tdoa_xcorr.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tdoa_xcorr.sv
// Two-channel TDOA estimator: captures WINDOW samples per mic, then serially cross-correlates
// over lags -MAX_LAG..+MAX_LAG and reports the peak lag. Define TDOA_CONTINUOUS_EN to free-run.
module tdoa_xcorr #(
  parameter  int WINDOW     = 256,
  parameter  int MAX_LAG    = 16,
  parameter  int DATA_WIDTH = 16,
  localparam int LAG_W      = $clog2(MAX_LAG) + 2,
  localparam int ACC_W      = 2 * DATA_WIDTH + $clog2(WINDOW)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         a_valid_in,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic                         b_valid_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic                         busy_out,
  output logic                         lag_valid_out,
  output logic signed [LAG_W-1:0]      lag_out,
  output logic signed [ACC_W-1:0]      peak_out
);

  localparam int AW = $clog2(WINDOW);
  localparam int CW = AW + 1;
  localparam int IW = AW + 2;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0]          N_LAST = AW'(WINDOW - 1);
  localparam logic signed [LAG_W-1:0] K_MIN = LAG_W'(-MAX_LAG);
  localparam logic signed [LAG_W-1:0] K_MAX = LAG_W'(MAX_LAG);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE} state_t;
  state_t state;

  logic signed [DATA_WIDTH-1:0] mem_a [WINDOW];
  logic signed [DATA_WIDTH-1:0] mem_b [WINDOW];
  logic signed [DATA_WIDTH-1:0] rd_a, rd_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          full_a, full_b, wr_a, wr_b;

  // Issue stage: one (n, k) term per cycle while issuing is set.
  logic                    issuing;
  logic [AW-1:0]           n_cnt;
  logic signed [LAG_W-1:0] k_cnt;
  logic signed [IW-1:0]    idx;
  logic                    in_range;

  logic                    s1_valid, s1_in, s1_first, s1_last, s1_first_lag, s1_final;
  logic signed [LAG_W-1:0] s1_lag;
  logic                    s2_valid, s2_first, s2_last, s2_first_lag, s2_final;
  logic signed [LAG_W-1:0] s2_lag;
  logic signed [PW-1:0]    mult, prod;
  logic signed [ACC_W-1:0] acc, acc_base, prod_ext, sum_next, best;
  logic signed [LAG_W-1:0] best_lag;
  logic                    fin;

  assign full_a   = (cnt_a == CW'(WINDOW));
  assign full_b   = (cnt_b == CW'(WINDOW));
  assign wr_a     = (state == CAPTURE) && a_valid_in && !full_a;
  assign wr_b     = (state == CAPTURE) && b_valid_in && !full_b;
  assign idx      = $signed({2'b00, n_cnt}) + IW'(k_cnt);
  assign in_range = (idx[IW-1:AW] == '0);

  // NOTE: sample buffers have no reset so they map onto block RAM; unwritten contents never matter.
  always_ff @(posedge clk_in) begin
    if (wr_a) mem_a[cnt_a[AW-1:0]] <= a_in;
    if (wr_b) mem_b[cnt_b[AW-1:0]] <= b_in;
    rd_a <= mem_a[n_cnt];
    rd_b <= mem_b[idx[AW-1:0]];
  end

  // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      busy_out      <= 1'b0;
      lag_valid_out <= 1'b0;
      lag_out       <= '0;
      peak_out      <= '0;
      cnt_a         <= '0;
      cnt_b         <= '0;
      issuing       <= 1'b0;
      n_cnt         <= '0;
      k_cnt         <= K_MIN;
    end else begin
      lag_valid_out <= 1'b0;
      if (wr_a) cnt_a <= cnt_a + CW'(1);
      if (wr_b) cnt_b <= cnt_b + CW'(1);
      if (issuing) begin
        if (n_cnt == N_LAST) begin
          n_cnt <= '0;
          if (k_cnt == K_MAX) issuing <= 1'b0;
          else                k_cnt   <= k_cnt + LAG_W'(1);
        end else begin
          n_cnt <= n_cnt + AW'(1);
        end
      end
      case (state)
        IDLE: begin
          // The result-strobe cycle still counts as busy for start requests.
          if (start_in && !lag_valid_out) begin
            state    <= CAPTURE;
            busy_out <= 1'b1;
            cnt_a    <= '0;
            cnt_b    <= '0;
          end
        end
        CAPTURE: begin
          if (full_a && full_b) begin
            state   <= COMPUTE;
            issuing <= 1'b1;
            n_cnt   <= '0;
            k_cnt   <= K_MIN;
          end
        end
        COMPUTE: begin
          if (fin) begin
            lag_out       <= best_lag;
            peak_out      <= best;
            lag_valid_out <= 1'b1;
`ifdef TDOA_CONTINUOUS_EN
            state         <= CAPTURE;
            cnt_a         <= '0;
            cnt_b         <= '0;
`else
            state         <= IDLE;
            busy_out      <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mult     = rd_a * rd_b;
  assign acc_base = s2_first ? '0 : acc;
  assign prod_ext = ACC_W'(prod);
  assign sum_next = acc_base + prod_ext;

  // Read -> multiply -> accumulate; best is updated on the last term of each lag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0; s1_in <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_first_lag <= 1'b0; s1_final <= 1'b0; s1_lag <= '0;
      s2_valid <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
      s2_first_lag <= 1'b0; s2_final <= 1'b0; s2_lag <= '0;
      prod     <= '0;
      acc      <= '0;
      best     <= '0;
      best_lag <= '0;
      fin      <= 1'b0;
    end else begin
      s1_valid     <= issuing;
      s1_in        <= in_range;
      s1_first     <= (n_cnt == '0);
      s1_last      <= (n_cnt == N_LAST);
      s1_first_lag <= (k_cnt == K_MIN);
      s1_final     <= (k_cnt == K_MAX);
      s1_lag       <= k_cnt;
      s2_valid     <= s1_valid;
      s2_first     <= s1_first;
      s2_last      <= s1_last;
      s2_first_lag <= s1_first_lag;
      s2_final     <= s1_final;
      s2_lag       <= s1_lag;
      prod         <= s1_in ? mult : '0;
      fin          <= s2_valid && s2_last && s2_final;
      if (s2_valid) begin
        acc <= sum_next;
        if (s2_last && (s2_first_lag || sum_next > best)) begin
          best     <= sum_next;
          best_lag <= s2_lag;
        end
      end
    end
  end

endmodule
